// File: rtl/arith_pkg.sv
// ---------------------------------------------------------------------------
// arith_pkg
//
// Shared definitions for the add/subtract sequencer and anything that talks
// to the 4-bit arithmetic unit.
//   ARITH_W        : operand/result width of the arithmetic unit
//   OP_ADD/OP_SUB  : operation encodings, also the unit's mux_sel values
//   ARITH_IDLE_VAL : value the unit drives on output_c while en=0
//   arith_state_t  : sequencer state encoding
// ---------------------------------------------------------------------------
package arith_pkg;

    localparam int unsigned ARITH_W = 4;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam logic [ARITH_W-1:0] ARITH_IDLE_VAL = {ARITH_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DRIVE   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_HOLD    = 2'd3
    } arith_state_t;

endpackage

// File: rtl/arith_op_sequencer.sv
// ---------------------------------------------------------------------------
// arith_op_sequencer
//
// Sequential initiator for the combinational 4-bit add/subtract unit.
// Accepts a request (op, a, b) on a valid/ready handshake, presents the
// operands to the unit from registers, captures output_c one cycle later and
// returns result + carry/borrow on a second valid/ready handshake.
// Also watches the unit while it is disabled and raises a sticky idle_err if
// it does not return IDLE_VAL.
//
// Ports:
//   clk, rst_n             clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready    request handshake
//   req_op, req_a, req_b   operation (0 add, 1 sub) and operands
//   req_acc                (ARITH_ACCUM_EN only) take operand A from the
//                          accumulator instead of req_a
//   alu_en/sel/a/b         drive the unit's en, mux_sel, input_a, input_b
//   alu_c                  the unit's output_c
//   res_valid/res_ready    result handshake
//   res_data, res_flag     captured result, carry (add) / borrow (sub)
//   idle_err               sticky: unit output != IDLE_VAL while disabled
//
// Build option: define ARITH_ACCUM_EN to add the req_acc port and an internal
// accumulator that follows every completed result transfer.
// ---------------------------------------------------------------------------
module arith_op_sequencer
    import arith_pkg::*;
#(
    parameter int unsigned      WIDTH    = ARITH_W,
    parameter logic [WIDTH-1:0] IDLE_VAL = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
`ifdef ARITH_ACCUM_EN
    input  logic             req_acc,
`endif
    output logic             alu_en,
    output logic             alu_sel,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_c,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_flag,
    output logic             idle_err
);

    arith_state_t     state_q,     state_d;
    logic             req_ready_q, req_ready_d;
    logic             alu_en_q,    alu_en_d;
    logic             alu_sel_q,   alu_sel_d;
    logic [WIDTH-1:0] alu_a_q,     alu_a_d;
    logic [WIDTH-1:0] alu_b_q,     alu_b_d;
    logic             res_valid_q, res_valid_d;
    logic [WIDTH-1:0] res_data_q,  res_data_d;
    logic             res_flag_q,  res_flag_d;
    logic             idle_err_q,  idle_err_d;
`ifdef ARITH_ACCUM_EN
    logic [WIDTH-1:0] acc_q,       acc_d;
`endif

    logic accept;
    logic xfer;

    assign accept = (state_q == ST_IDLE) && req_valid && req_ready_q;
    assign xfer   = (state_q == ST_HOLD) && res_ready;

    // State and output registers.
    // NOTE: sequential state is updated with non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            req_ready_q <= 1'b1;
            alu_en_q    <= 1'b0;
            alu_sel_q   <= 1'b0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_flag_q  <= 1'b0;
            idle_err_q  <= 1'b0;
`ifdef ARITH_ACCUM_EN
            acc_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            alu_en_q    <= alu_en_d;
            alu_sel_q   <= alu_sel_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_flag_q  <= res_flag_d;
            idle_err_q  <= idle_err_d;
`ifdef ARITH_ACCUM_EN
            acc_q       <= acc_d;
`endif
        end
    end

    // Next-state logic.
    // NOTE: every combinational output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (accept) state_d = ST_DRIVE;
            ST_DRIVE:   state_d = ST_CAPTURE;   // unit settles during this cycle
            ST_CAPTURE: state_d = ST_HOLD;
            ST_HOLD:    if (res_ready) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs.
    always_comb begin
        req_ready_d = req_ready_q;
        alu_en_d    = alu_en_q;
        alu_sel_d   = alu_sel_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        res_flag_d  = res_flag_q;
        idle_err_d  = idle_err_q;
`ifdef ARITH_ACCUM_EN
        acc_d       = acc_q;
`endif
        case (state_q)
            ST_IDLE: begin
                // alu_en_q low at this edge means the unit was disabled for the
                // whole preceding cycle, so its output must have settled.
                if (!alu_en_q && (alu_c != IDLE_VAL)) idle_err_d = 1'b1;
                if (accept) begin
                    req_ready_d = 1'b0;
                    alu_en_d    = 1'b1;
                    alu_sel_d   = req_op;
`ifdef ARITH_ACCUM_EN
                    alu_a_d     = req_acc ? acc_q : req_a;
`else
                    alu_a_d     = req_a;
`endif
                    alu_b_d     = req_b;
                end
            end
            ST_CAPTURE: begin
                res_data_d  = alu_c;
                // Modulo sum smaller than an operand <=> carry out of WIDTH bits.
                res_flag_d  = (alu_sel_q == OP_SUB) ? (alu_a_q < alu_b_q)
                                                    : (alu_c < alu_a_q);
                res_valid_d = 1'b1;
                alu_en_d    = 1'b0;
            end
            ST_HOLD: begin
                if (xfer) begin
                    res_valid_d = 1'b0;
                    req_ready_d = 1'b1;
`ifdef ARITH_ACCUM_EN
                    acc_d       = res_data_q;
`endif
                end
            end
            default: ;
        endcase
    end

    assign req_ready = req_ready_q;
    assign alu_en    = alu_en_q;
    assign alu_sel   = alu_sel_q;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_flag  = res_flag_q;
    assign idle_err  = idle_err_q;

endmodule

// File: tb/tb_arith_op_sequencer.sv
// ---------------------------------------------------------------------------
// tb_arith_op_sequencer
//
// Drives arith_op_sequencer wired to a behavioural model of the 4-bit
// add/subtract unit (en=0 -> all ones). Expected results come from a vector
// table of hand-computed constants; they are pushed to a scoreboard queue on
// request acceptance and popped when the result transfer happens.
// Build with +define+ARITH_ACCUM_EN to exercise the accumulator option.
// ---------------------------------------------------------------------------
module tb_arith_op_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req_valid, req_ready, req_op, req_acc;
    logic [3:0] req_a, req_b;
    logic       alu_en, alu_sel;
    logic [3:0] alu_a, alu_b, alu_c;
    logic       res_valid, res_ready, res_flag, idle_err;
    logic [3:0] res_data;
    logic       force_zero;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [3:0] data;
        logic       flag;
    } exp_t;

    typedef struct {
        logic       op;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] d;
        logic       f;
    } vec_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    // Stand-in for the team's add/subtract unit.
    always_comb begin
        if (force_zero)   alu_c = 4'h0;
        else if (!alu_en) alu_c = 4'hF;
        else if (alu_sel) alu_c = alu_a - alu_b;
        else              alu_c = alu_a + alu_b;
    end

    arith_op_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
`ifdef ARITH_ACCUM_EN
        .req_acc   (req_acc),
`endif
        .alu_en    (alu_en),
        .alu_sel   (alu_sel),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_c     (alu_c),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_flag  (res_flag),
        .idle_err  (idle_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One full request/result transaction. Called #1 after a rising edge.
    task automatic do_op(input logic op, input logic [3:0] a, input logic [3:0] b,
                         input logic acc, input logic [3:0] ed, input logic ef,
                         input int stall);
        int   n;
        exp_t e;
        n = 0;
        while (!req_ready && n < 20) begin
            cyc();
            n++;
        end
        check("req_ready_wait", req_ready, 1);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_acc   = acc;
        cyc();                                  // acceptance edge
        exp_q.push_back('{data: ed, flag: ef});
        req_valid = 1'b0;
        req_a     = ~a;                         // must not be resampled
        req_b     = ~b;
        check("drive_en", alu_en, 1);
        check("drive_ready", req_ready, 0);
        cyc();
        check("lat1_valid", res_valid, 0);
        cyc();
        check("lat2_valid", res_valid, 1);
        for (int i = 0; i < stall; i++) begin
            req_valid = 1'b1;                   // must be ignored while busy
            check("stall_ready", req_ready, 0);
            check("stall_data", {res_valid, res_data, res_flag}, {1'b1, ed, ef});
            cyc();
        end
        req_valid = 1'b0;
        res_ready = 1'b1;
        if (exp_q.size() == 0) begin
            check("sb_empty", 1, 0);
        end else begin
            e = exp_q.pop_front();
            check("res_data", res_data, e.data);
            check("res_flag", res_flag, e.flag);
        end
        cyc();                                  // transfer edge
        res_ready = 1'b0;
        check("post_valid", res_valid, 0);
        check("post_ready", req_ready, 1);
        check("post_en", alu_en, 0);
    endtask

    vec_t vecs[8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{op: 1'b0, a: 4'h7, b: 4'h5, d: 4'hC, f: 1'b0};
        vecs[1] = '{op: 1'b0, a: 4'hF, b: 4'h1, d: 4'h0, f: 1'b1};
        vecs[2] = '{op: 1'b1, a: 4'h9, b: 4'h4, d: 4'h5, f: 1'b0};
        vecs[3] = '{op: 1'b1, a: 4'h3, b: 4'h5, d: 4'hE, f: 1'b1};
        vecs[4] = '{op: 1'b0, a: 4'h8, b: 4'h8, d: 4'h0, f: 1'b1};
        vecs[5] = '{op: 1'b1, a: 4'h0, b: 4'h0, d: 4'h0, f: 1'b0};
        vecs[6] = '{op: 1'b1, a: 4'h0, b: 4'h1, d: 4'hF, f: 1'b1};
        vecs[7] = '{op: 1'b0, a: 4'h6, b: 4'h9, d: 4'hF, f: 1'b0};

        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_op     = 1'b0;
        req_a      = 4'h0;
        req_b      = 4'h0;
        req_acc    = 1'b0;
        res_ready  = 1'b0;
        force_zero = 1'b0;
        #23;
        check("reset_outs",
              {req_ready, alu_en, alu_sel, alu_a, alu_b, res_valid, res_data, res_flag, idle_err},
              {1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0});
        rst_n = 1'b1;
        cyc();

        // Table-driven operations, res_ready raised in the cycle res_valid rises.
        for (int i = 0; i < 8; i++)
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, vecs[i].d, vecs[i].f, 0);

        // Backpressure: result held for 5 cycles, new requests ignored.
        do_op(1'b0, 4'h2, 4'h3, 1'b0, 4'h5, 1'b0, 5);

        // The unit model returns all ones when disabled.
        cyc();
        check("idle_err_clean", idle_err, 0);

        // Broken unit while disabled -> sticky error.
        force_zero = 1'b1;
        cyc();
        cyc();
        force_zero = 1'b0;
        check("idle_err_set", idle_err, 1);
        do_op(1'b1, 4'hA, 4'h9, 1'b0, 4'h1, 1'b0, 0);
        check("idle_err_sticky", idle_err, 1);

        // Asynchronous reset while a result is held.
        req_valid = 1'b1;
        req_op    = 1'b0;
        req_a     = 4'h4;
        req_b     = 4'h4;
        cyc();
        req_valid = 1'b0;
        cyc();
        cyc();
        check("hold_before_reset", {res_valid, res_data}, {1'b1, 4'h8});
        #2 rst_n = 1'b0;
        #1;
        check("reset_mid_hold",
              {req_ready, alu_en, alu_sel, alu_a, alu_b, res_valid, res_data, res_flag, idle_err},
              {1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 4'h0, 1'b0, 1'b0});
        #4 rst_n = 1'b1;
        cyc();
        check("after_reset", {req_ready, res_valid}, {1'b1, 1'b0});
        exp_q.delete();

`ifdef ARITH_ACCUM_EN
        // Accumulator chain; req_a is garbage whenever req_acc=1.
        do_op(1'b0, 4'h3, 4'h4, 1'b0, 4'h7, 1'b0, 0);
        do_op(1'b1, 4'hA, 4'h2, 1'b1, 4'h5, 1'b0, 0);
        do_op(1'b0, 4'hA, 4'hC, 1'b1, 4'h1, 1'b1, 0);
`endif

        check("sb_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/arith_op_sequencer.md
Name: arith_op_sequencer

Overview:
- Sequential initiator that drives the team's combinational 4-bit add/subtract unit. That unit has ports en, mux_sel, input_a, input_b and output_c.
- Accepts operation requests over a valid/ready handshake. Presents registered operands to the unit, captures its result one cycle later, and returns the result plus a carry/borrow flag over a second valid/ready handshake.
- Sits between the switch/keypad front end and the display path.

Parameters:
- WIDTH, 4: operand and result width. Must match the arithmetic unit.
- IDLE_VAL, all ones ({WIDTH{1'b1}}): value the unit outputs when en=0. Used only for the idle check.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  sequencer can accept a request.
- req_op  input  1  operation: 0 = add, 1 = subtract.
- req_a  input  WIDTH  operand A.
- req_b  input  WIDTH  operand B.
- alu_en  output  1  drives the unit's en.
- alu_sel  output  1  drives the unit's mux_sel.
- alu_a  output  WIDTH  drives the unit's input_a.
- alu_b  output  WIDTH  drives the unit's input_b.
- alu_c  input  WIDTH  driven by the unit's output_c.
- res_valid  output  1  result present.
- res_ready  input  1  downstream accepts the result.
- res_data  output  WIDTH  captured result.
- res_flag  output  1  carry-out for add, borrow for subtract.
- idle_err  output  1  sticky flag: the unit did not return IDLE_VAL while disabled.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values: state=IDLE, req_ready=1, alu_en=0, alu_sel=0, alu_a=0, alu_b=0, res_valid=0, res_data=0, res_flag=0, idle_err=0.
- All outputs are registered.
- Reset asserted mid-operation aborts immediately to the reset values. Any in-flight request or result is discarded.
- State machine, states IDLE, DRIVE, CAPTURE, HOLD:
  - IDLE: req_ready=1, alu_en=0. When req_valid && req_ready, latch op/a/b into alu_sel/alu_a/alu_b, set alu_en=1, go to DRIVE.
  - DRIVE: req_ready=0. The unit settles combinationally. Go to CAPTURE unconditionally.
  - CAPTURE: register res_data <= alu_c.
    - Add: res_flag <= (alu_c < alu_a), i.e. the WIDTH-bit carry-out.
    - Subtract: res_flag <= (alu_a < alu_b), i.e. borrow.
    - Set res_valid=1, alu_en=0, go to HOLD.
  - HOLD: hold res_data/res_flag stable while res_valid=1. When res_ready=1, clear res_valid and go to IDLE.
- Timing:
  - Latency from request acceptance edge to res_valid=1 is 2 cycles.
  - res_ready asserted in the same cycle res_valid rises completes the transfer at that edge.
  - Back-to-back throughput is one operation per 4 cycles.
- Wrap-around:
  - Results are modulo 2^WIDTH, with no saturation.
  - Example: 0xF + 0x1 = 0x0 with flag=1.
  - Example: 0x3 - 0x5 = 0xE with flag=1.
- Idle check: in IDLE, with alu_en=0 held for at least one full cycle, idle_err is set if alu_c != IDLE_VAL. idle_err clears only on reset.
- Handshake:
  - req_valid is ignored when req_ready=0. Inputs are sampled only on the acceptance edge.
  - res_ready is ignored outside HOLD.

Optional Feature:
- Macro: ARITH_ACCUM_EN.
- Defined:
  - Adds input port req_acc (1 bit).
  - On acceptance with req_acc=1, alu_a is loaded from an internal accumulator instead of req_a.
  - The accumulator resets to 0 and loads res_data on every completed result transfer.
- Not defined: port req_acc and the accumulator do not exist, and alu_a always comes from req_a.

Decomposition:
- Shared package arith_pkg:
  - ARITH_W = 4.
  - Op encodings OP_ADD = 1'b0 and OP_SUB = 1'b1.
  - State typedef/localparams for IDLE/DRIVE/CAPTURE/HOLD.
  - IDLE_VAL constant.
- No sub-module is required. For system tests the bench instantiates the existing arithmetic unit beside the sequencer and wires alu_* to en/mux_sel/input_a/input_b/output_c.

Test Plan:
- Reset: assert rst_n=0 mid-HOLD -> all outputs return to reset values asynchronously; after release req_ready=1 and res_valid=0.
- Add: req op=0, a=0x7, b=0x5 -> res_valid exactly 2 cycles after acceptance, res_data=0xC, res_flag=0; then a=0xF, b=0x1 -> res_data=0x0, res_flag=1.
- Subtract: a=0x9, b=0x4 -> 0x5, flag=0; a=0x3, b=0x5 -> 0xE, flag=1.
- Backpressure: hold res_ready=0 for 5 cycles -> res_data stable, req_ready=0, new req_valid ignored; raise res_ready -> one transfer, then IDLE.
- Idle check: force alu_c=0x0 while alu_en=0 -> idle_err=1 and stays 1 until reset; with the real unit connected idle_err stays 0.
- ARITH_ACCUM_EN: add 0x3+0x4 -> 0x7; then req_acc=1, sub b=0x2 -> 0x5; then req_acc=1, add b=0xC -> 0x1 with flag=1.
